spectrum_bar_engine: RTL and testbench

- Converts one frame of FFT bin magnitudes into NUM_BARS display bars, each with exponential fall-off and a peak-hold marker.
- Sits between mag_est and graphics_controller.
- Consumes magnitudes as a valid/ready stream after each FFT done.
- Exposes bars and peaks through a registered random-read port.
- Replaces the fixed one-bin-per-column path with a configurable bar count and temporal smoothing.

---
 rtl/spectrum_bar_engine.sv | 157 +++++++++++++++
 tb/tb_spectrum_bar_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_engine.sv
// Groups one frame of FFT bin magnitudes into NUM_BARS display bars with
// exponential fall-off and peak hold. Bars and peaks are read back through a registered port.
module spectrum_bar_engine #(
   parameter int N           = 256,
   parameter int MAG_W       = 14,
   parameter int NUM_BARS    = 16,
   parameter int DECAY_SHIFT = 3,
   parameter int HOLD_FRAMES = 8,
   parameter int SKIP_DC     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_start,
   input  logic                        mag_valid,
   input  logic [MAG_W-1:0]            mag_data,
   output logic                        mag_ready,
   output logic                        busy,
   output logic                        frame_done,
   output logic [7:0]                  overrun_cnt,
   input  logic [$clog2(NUM_BARS)-1:0] rd_idx,
   output logic [MAG_W-1:0]            rd_bar,
   output logic [MAG_W-1:0]            rd_peak
);
   localparam int BINS   = N / 2;
   localparam int BPB    = BINS / NUM_BARS;
   localparam int BIN_W  = $clog2(BINS);
   localparam int BAR_W  = $clog2(NUM_BARS);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [BIN_W-1:0]  GRP_MASK  = BIN_W'(BPB - 1);
   localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(BINS - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t            state;
   logic [BIN_W-1:0]  bin_idx;
   logic [MAG_W-1:0]  grp_max;
   logic [MAG_W-1:0]  bar_mem  [NUM_BARS];
   logic [MAG_W-1:0]  peak_mem [NUM_BARS];
   logic [HOLD_W-1:0] hold_mem [NUM_BARS];

   logic              beat_acc;
   logic              grp_end;
   logic [BAR_W-1:0]  bar_sel;
   logic [MAG_W-1:0]  beat_val;
   logic [MAG_W-1:0]  cand;
   logic [MAG_W-1:0]  cur_bar;
   logic [MAG_W-1:0]  cur_peak;
   logic [HOLD_W-1:0] cur_hold;
   logic [MAG_W-1:0]  bar_fall;
   logic [MAG_W-1:0]  bar_next;
   logic [MAG_W-1:0]  peak_next;
   logic [HOLD_W-1:0] hold_next;

   // Fall-off step: a fraction of the value, but at least 1 so bars always reach 0.
   function automatic logic [MAG_W-1:0] decay_of(input logic [MAG_W-1:0] v);
      logic [MAG_W-1:0] d;
      d = v >> DECAY_SHIFT;
      if (d == '0 && v != '0)
         d = MAG_W'(1);
      return d;
   endfunction

   assign beat_acc = mag_valid && mag_ready;
   assign grp_end  = (bin_idx & GRP_MASK) == GRP_MASK;
   assign bar_sel  = BAR_W'(bin_idx >> $clog2(BPB));

   // NOTE: every output of this block gets a default at the top so no path leaves a latch.
   always_comb begin
      beat_val  = (SKIP_DC != 0 && bin_idx == '0) ? '0 : mag_data;
      cand      = (beat_val > grp_max) ? beat_val : grp_max;
      cur_bar   = bar_mem[bar_sel];
      cur_peak  = peak_mem[bar_sel];
      cur_hold  = hold_mem[bar_sel];
      bar_fall  = cur_bar - decay_of(cur_bar);
      bar_next  = (cand > bar_fall) ? cand : bar_fall;
      peak_next = cur_peak;
      hold_next = cur_hold;
      if (cand >= cur_peak) begin
         peak_next = cand;
         hold_next = HOLD_INIT;
      end else if (cur_hold != '0) begin
         hold_next = cur_hold - HOLD_W'(1);
      end else begin
         peak_next = cur_peak - decay_of(cur_peak);
      end
      // A fresh candidate can land between the decayed peak and the old peak.
      if (peak_next < bar_next)
         peak_next = bar_next;
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         bin_idx     <= '0;
         grp_max     <= '0;
         mag_ready   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun_cnt <= '0;
         rd_bar      <= '0;
         rd_peak     <= '0;
         // NOTE: the bar arrays are flops, not RAM, so they can and must be cleared on reset.
         for (int i = 0; i < NUM_BARS; i++) begin
            bar_mem[i]  <= '0;
            peak_mem[i] <= '0;
            hold_mem[i] <= '0;
         end
      end else begin
         rd_bar     <= bar_mem[rd_idx];
         rd_peak    <= peak_mem[rd_idx];
         frame_done <= 1'b0;
         if (frame_start && state != S_IDLE && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state     <= S_ACCUM;
                  bin_idx   <= '0;
                  grp_max   <= '0;
                  mag_ready <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (beat_acc) begin
                  bin_idx <= bin_idx + BIN_W'(1);
                  if (grp_end) begin
                     grp_max           <= '0;
                     bar_mem[bar_sel]  <= bar_next;
                     peak_mem[bar_sel] <= peak_next;
                     hold_mem[bar_sel] <= hold_next;
                  end else begin
                     grp_max <= cand;
                  end
                  if (bin_idx == LAST_BIN) begin
                     state      <= S_DONE;
                     mag_ready  <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               mag_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_bar_engine.sv
// Randomised bench for spectrum_bar_engine: a frame-level reference model checks
// two instances (SKIP_DC=1 and SKIP_DC=0) driven with identical streams.
module tb_spectrum_bar_engine;
   localparam int N    = 256;
   localparam int BINS = N / 2;
   localparam int NB   = 16;
   localparam int BPB  = BINS / NB;
   localparam int DSH  = 3;
   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        mag_valid = 1'b0;
   logic [13:0] mag_data = '0;
   logic [3:0]  rd_idx = '0;

   logic        mag_ready, busy, frame_done;
   logic [7:0]  overrun_cnt;
   logic [13:0] rd_bar, rd_peak;
   logic        mag_ready_dc, busy_dc, frame_done_dc;
   logic [7:0]  overrun_cnt_dc;
   logic [13:0] rd_bar_dc, rd_peak_dc;

   int errors = 0;
   int checks = 0;

   logic [13:0] frame_data [BINS];
   int m_bar  [2][NB];
   int m_peak [2][NB];
   int m_hold [2][NB];
   int m_overrun;
   int got_bar  [2][NB];
   int got_peak [2][NB];

   always #5 clk = ~clk;

   spectrum_bar_engine #(.N(N), .MAG_W(14), .NUM_BARS(NB), .DECAY_SHIFT(DSH),
                         .HOLD_FRAMES(HOLD), .SKIP_DC(1)) u_dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .mag_valid(mag_valid),
      .mag_data(mag_data), .mag_ready(mag_ready), .busy(busy), .frame_done(frame_done),
      .overrun_cnt(overrun_cnt), .rd_idx(rd_idx), .rd_bar(rd_bar), .rd_peak(rd_peak));

   spectrum_bar_engine #(.N(N), .MAG_W(14), .NUM_BARS(NB), .DECAY_SHIFT(DSH),
                         .HOLD_FRAMES(HOLD), .SKIP_DC(0)) u_dut_dc (
      .clk(clk), .rst(rst), .frame_start(frame_start), .mag_valid(mag_valid),
      .mag_data(mag_data), .mag_ready(mag_ready_dc), .busy(busy_dc),
      .frame_done(frame_done_dc), .overrun_cnt(overrun_cnt_dc), .rd_idx(rd_idx),
      .rd_bar(rd_bar_dc), .rd_peak(rd_peak_dc));

   function automatic int f_dec(input int x);
      int d;
      d = x / (1 << DSH);
      return (d == 0 && x != 0) ? 1 : d;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++)
         for (int g = 0; g < NB; g++) begin
            m_bar[u][g] = 0; m_peak[u][g] = 0; m_hold[u][g] = 0;
         end
      m_overrun = 0;
   endtask

   // Whole-frame update: instance 0 drops bin 0, instance 1 keeps it.
   task automatic model_frame();
      for (int u = 0; u < 2; u++)
         for (int g = 0; g < NB; g++) begin
            int cand, nb, np;
            cand = 0;
            for (int k = 0; k < BPB; k++) begin
               int b, v;
               b = g * BPB + k;
               v = (u == 0 && b == 0) ? 0 : int'(frame_data[b]);
               if (v > cand) cand = v;
            end
            nb = m_bar[u][g] - f_dec(m_bar[u][g]);
            if (cand > nb) nb = cand;
            np = m_peak[u][g];
            if (cand >= m_peak[u][g]) begin
               np = cand; m_hold[u][g] = HOLD;
            end else if (m_hold[u][g] > 0) begin
               m_hold[u][g] = m_hold[u][g] - 1;
            end else begin
               np = m_peak[u][g] - f_dec(m_peak[u][g]);
            end
            if (np < nb) np = nb;
            m_bar[u][g] = nb; m_peak[u][g] = np;
         end
   endtask

   task automatic set_zero();
      for (int b = 0; b < BINS; b++) frame_data[b] = '0;
   endtask

   task automatic set_random();
      for (int b = 0; b < BINS; b++)
         frame_data[b] = ($urandom_range(3) == 0) ? 14'd0 : 14'($urandom_range(16383));
   endtask

   task automatic do_reset();
      rst = 1'b1; frame_start = 1'b0; mag_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic read_all();
      for (int i = 0; i < NB; i++) begin
         rd_idx = 4'(i);
         @(negedge clk);
         got_bar[0][i] = int'(rd_bar);    got_peak[0][i] = int'(rd_peak);
         got_bar[1][i] = int'(rd_bar_dc); got_peak[1][i] = int'(rd_peak_dc);
      end
   endtask

   // Streams frame_data as one frame; called at a negedge with the DUT idle.
   task automatic run_frame(input int duty, input bit spam_fs, input bit fs_on_done,
                            output int ready_cycles, output int done_total,
                            output bit done_after_last, output bit busy_after);
      int accepted, cyc, spam_cnt;
      accepted = 0; cyc = 0; spam_cnt = 0; ready_cycles = 0; done_total = 0;
      frame_start = 1'b1; mag_valid = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
      while (accepted < BINS && cyc < 4000) begin
         mag_valid   = ($urandom_range(99) < duty);
         mag_data    = mag_valid ? frame_data[accepted] : 14'($urandom_range(16383));
         frame_start = spam_fs && spam_cnt < 300;
         if (frame_start) spam_cnt++;
         if (mag_ready) ready_cycles++;
         if (frame_done) done_total++;
         if (mag_valid && mag_ready) accepted++;
         @(negedge clk);
         cyc++;
      end
      mag_valid = 1'b0;
      frame_start = fs_on_done;
      if (accepted < BINS) begin
         errors++; checks++;
         $display("FAIL frame_timeout: accepted %0d beats, need %0d", accepted, BINS);
      end
      done_after_last = frame_done;
      if (mag_ready) ready_cycles++;
      if (frame_done) done_total++;
      m_overrun = m_overrun + spam_cnt + int'(fs_on_done);
      if (m_overrun > 255) m_overrun = 255;
      @(negedge clk);
      frame_start = 1'b0;
      busy_after = busy || mag_ready;
      for (int i = 0; i < 3; i++) begin
         if (mag_ready) ready_cycles++;
         if (frame_done) done_total++;
         @(negedge clk);
      end
      model_frame();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (mag_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mag_ready); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
      checks++; if (rd_bar !== 14'd0 || rd_peak !== 14'd0) begin
         errors++; $display("FAIL reset_rd: got bar %0d peak %0d want 0", rd_bar, rd_peak); end
      read_all();
      for (int i = 0; i < NB; i++) begin
         checks++; if (got_bar[0][i] !== 0 || got_peak[0][i] !== 0) begin
            errors++; $display("FAIL reset_bar%0d: got %0d/%0d want 0/0", i, got_bar[0][i], got_peak[0][i]); end
      end
   endtask

   task automatic test_single_tone();
      int rc, dt; bit dal, ba;
      set_zero(); frame_data[20] = 14'd1000;
      run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
      checks++; if (rc !== BINS) begin errors++; $display("FAIL tone_ready_cycles: got %0d want %0d", rc, BINS); end
      checks++; if (dal !== 1'b1) begin errors++; $display("FAIL tone_done_timing: got %b want 1", dal); end
      checks++; if (dt !== 1) begin errors++; $display("FAIL tone_done_count: got %0d want 1", dt); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL tone_idle_after: got %b want 0", ba); end
      read_all();
      checks++; if (got_bar[0][2] !== 1000 || got_peak[0][2] !== 1000) begin
         errors++; $display("FAIL tone_bar2: got %0d/%0d want 1000/1000", got_bar[0][2], got_peak[0][2]); end
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < NB; i++) begin
            checks++; if (got_bar[u][i] !== m_bar[u][i] || got_peak[u][i] !== m_peak[u][i]) begin
               errors++; $display("FAIL tone_model u%0d bar%0d: got %0d/%0d want %0d/%0d",
                                  u, i, got_bar[u][i], got_peak[u][i], m_bar[u][i], m_peak[u][i]); end
         end
   endtask

   task automatic test_decay();
      int rc, dt; bit dal, ba;
      int exp_bar [9] = '{875, 766, 671, 588, 515, 451, 395, 346, 303};
      int exp_peak[9] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 875};
      set_zero();
      for (int f = 0; f < 9; f++) begin
         run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
         read_all();
         checks++; if (got_bar[0][2] !== exp_bar[f] || got_peak[0][2] !== exp_peak[f]) begin
            errors++; $display("FAIL decay_f%0d: got %0d/%0d want %0d/%0d",
                               f + 1, got_bar[0][2], got_peak[0][2], exp_bar[f], exp_peak[f]); end
         for (int i = 0; i < NB; i++) begin
            checks++; if (got_bar[0][i] !== m_bar[0][i] || got_peak[0][i] !== m_peak[0][i]) begin
               errors++; $display("FAIL decay_model f%0d bar%0d: got %0d/%0d want %0d/%0d",
                                  f + 1, i, got_bar[0][i], got_peak[0][i], m_bar[0][i], m_peak[0][i]); end
         end
      end
   endtask

   task automatic test_min_decay();
      int rc, dt; bit dal, ba;
      do_reset();
      set_zero(); frame_data[5 * BPB + 3] = 14'd5;
      run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
      set_zero();
      run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
      read_all();
      checks++; if (got_bar[0][5] !== 4 || got_peak[0][5] !== 5) begin
         errors++; $display("FAIL min_decay: got %0d/%0d want 4/5", got_bar[0][5], got_peak[0][5]); end
   endtask

   task automatic test_skip_dc();
      int rc, dt; bit dal, ba;
      do_reset();
      set_zero(); frame_data[0] = 14'd16383;
      run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
      read_all();
      checks++; if (got_bar[0][0] !== 0 || got_peak[0][0] !== 0) begin
         errors++; $display("FAIL skip_dc_on: got %0d/%0d want 0/0", got_bar[0][0], got_peak[0][0]); end
      checks++; if (got_bar[1][0] !== 16383 || got_peak[1][0] !== 16383) begin
         errors++; $display("FAIL skip_dc_off: got %0d/%0d want 16383/16383", got_bar[1][0], got_peak[1][0]); end
   endtask

   task automatic test_random_valid();
      int rc, dt, idle_ready; bit dal, ba;
      do_reset();
      idle_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if (mag_ready) idle_ready++;
         @(negedge clk);
      end
      checks++; if (idle_ready !== 0) begin errors++; $display("FAIL idle_ready: got %0d high cycles want 0", idle_ready); end
      set_zero(); frame_data[20] = 14'd1000;
      run_frame(50, 1'b0, 1'b0, rc, dt, dal, ba);
      checks++; if (dal !== 1'b1) begin errors++; $display("FAIL gappy_done_timing: got %b want 1", dal); end
      checks++; if (dt !== 1) begin errors++; $display("FAIL gappy_done_count: got %0d want 1", dt); end
      read_all();
      for (int i = 0; i < NB; i++) begin
         checks++; if (got_bar[0][i] !== m_bar[0][i] || got_peak[0][i] !== m_peak[0][i]) begin
            errors++; $display("FAIL gappy_bar%0d: got %0d/%0d want %0d/%0d",
                               i, got_bar[0][i], got_peak[0][i], m_bar[0][i], m_peak[0][i]); end
      end
   endtask

   task automatic test_back_to_back();
      int rc, dt; bit dal, ba;
      set_random();
      run_frame(100, 1'b0, 1'b1, rc, dt, dal, ba);
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got busy %b want 0", ba); end
      checks++; if (int'(overrun_cnt) !== m_overrun) begin
         errors++; $display("FAIL b2b_overrun: got %0d want %0d", overrun_cnt, m_overrun); end
   endtask

   task automatic test_overrun();
      int rc, dt; bit dal, ba;
      set_random();
      run_frame(30, 1'b1, 1'b0, rc, dt, dal, ba);
      checks++; if (overrun_cnt !== 8'd255 || m_overrun !== 255) begin
         errors++; $display("FAIL overrun_sat: got %0d want 255 (model %0d)", overrun_cnt, m_overrun); end
      checks++; if (dt !== 1) begin errors++; $display("FAIL overrun_done_count: got %0d want 1", dt); end
      read_all();
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < NB; i++) begin
            checks++; if (got_bar[u][i] !== m_bar[u][i] || got_peak[u][i] !== m_peak[u][i]) begin
               errors++; $display("FAIL overrun_model u%0d bar%0d: got %0d/%0d want %0d/%0d",
                                  u, i, got_bar[u][i], got_peak[u][i], m_bar[u][i], m_peak[u][i]); end
         end
   endtask

   task automatic test_reset_mid_frame();
      int accepted, cyc, done_seen, rc, dt; bit dal, ba;
      set_random();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      accepted = 0; cyc = 0;
      while (accepted < 50 && cyc < 1000) begin
         mag_valid = 1'b1;
         mag_data  = frame_data[accepted];
         if (mag_ready) accepted++;
         @(negedge clk);
         cyc++;
      end
      mag_data = frame_data[accepted];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mag_valid = 1'b0;
      model_reset();
      checks++; if (busy !== 1'b0 || mag_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_idle: got busy %b ready %b want 0 0", busy, mag_ready); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL midrst_overrun: got %0d want 0", overrun_cnt); end
      checks++; if (rd_bar !== 14'd0 || rd_peak !== 14'd0) begin
         errors++; $display("FAIL midrst_rd: got %0d/%0d want 0/0", rd_bar, rd_peak); end
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (frame_done) done_seen++;
         @(negedge clk);
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
      read_all();
      for (int i = 0; i < NB; i++) begin
         checks++; if (got_bar[0][i] !== 0 || got_peak[0][i] !== 0) begin
            errors++; $display("FAIL midrst_clear%0d: got %0d/%0d want 0/0", i, got_bar[0][i], got_peak[0][i]); end
      end
      set_random();
      run_frame(100, 1'b0, 1'b0, rc, dt, dal, ba);
      checks++; if (dt !== 1) begin errors++; $display("FAIL midrst_refill_done: got %0d want 1", dt); end
      read_all();
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < NB; i++) begin
            checks++; if (got_bar[u][i] !== m_bar[u][i] || got_peak[u][i] !== m_peak[u][i]) begin
               errors++; $display("FAIL midrst_model u%0d bar%0d: got %0d/%0d want %0d/%0d",
                                  u, i, got_bar[u][i], got_peak[u][i], m_bar[u][i], m_peak[u][i]); end
         end
   endtask

   task automatic test_random_frames();
      int rc, dt; bit dal, ba;
      for (int f = 0; f < 6; f++) begin
         if (f % 2 == 0) set_random(); else set_zero();
         run_frame(int'($urandom_range(100, 20)), 1'b0, 1'b0, rc, dt, dal, ba);
         read_all();
         for (int u = 0; u < 2; u++)
            for (int i = 0; i < NB; i++) begin
               checks++; if (got_bar[u][i] !== m_bar[u][i] || got_peak[u][i] !== m_peak[u][i]) begin
                  errors++; $display("FAIL rand_f%0d u%0d bar%0d: got %0d/%0d want %0d/%0d",
                                     f, u, i, got_bar[u][i], got_peak[u][i], m_bar[u][i], m_peak[u][i]); end
            end
      end
   endtask

   initial begin
      test_reset();
      test_single_tone();
      test_decay();
      test_min_decay();
      test_skip_dc();
      test_random_valid();
      test_back_to_back();
      test_overrun();
      test_reset_mid_frame();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end
endmodule
